text_plotter: RTL
=================

Name: text_plotter

Overview:
- Parametrised successor to the single-word drawer: renders a string of up to MAX_CHARS character codes, held in the 32x4 character RAM, as bitmap glyphs.
- Emits one pixel per cycle on the vga_adapter plot interface (x, y, colour, plot).
- Sits between the character RAM and vga_adapter; the top level arbitrates RAM ownership while busy is high.
- Adds over the old drawer: runtime origin, length, fg/bg colours, clipping, busy/done handshake.

Parameters:
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- X_MAX, 160: first x column that is clipped (not plotted).
- Y_MAX, 120: first y row that is clipped (not plotted).
- ADDR_W, 5: character RAM address width; MAX_CHARS = 2**ADDR_W.
- CHAR_W, 4: character code width.
- COL_W, 3: colour width.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x0  in  X_W  top-left x of first cell, latched at start
- y0  in  Y_W  top-left y, latched at start
- len  in  ADDR_W+1  character count 0..MAX_CHARS, latched at start
- fg_colour  in  COL_W  glyph-on colour, latched at start
- bg_colour  in  COL_W  glyph-off and gap colour, latched at start
- ram_address  out  ADDR_W  character RAM address
- ram_q  in  CHAR_W  RAM read data, valid 1 cycle after address
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  COL_W  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state, including mid-string): state IDLE; all outputs 0; counters and latched inputs 0. No partial pixel is emitted after reset.
- Glyph cell: GLYPH_W=5 x GLYPH_H=7, plus one gap column drawn in bg_colour. Cell pitch is 6 columns.
- Character i occupies columns x0+6i .. x0+6i+5 and rows y0 .. y0+6.
- FSM states: IDLE, FETCH, WAIT, DRAW, FIN.
- IDLE: on start=1, latch the inputs and set char index i=0.
  - If len==0, go to FIN.
  - Otherwise go to FETCH.
- FETCH: drive ram_address=i; go to WAIT.
- WAIT: RAM latency cycle; ram_q is captured at the end of this cycle into the code register; go to DRAW.
- DRAW: emits one pixel per cycle, 42 cycles per character.
  - Order: row-major, column cx 0..5 within row cy 0..6.
  - colour = fg_colour if cx<5 and the font bit (code, cy, cx) is 1; otherwise bg_colour.
  - After cx=5, cy=6: increment i. If i==len go to FIN, else go to FETCH.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle; return to IDLE.
- Timing:
  - Start sampled at edge E. FETCH is the cycle after E; the first plot is asserted 2 cycles later.
  - Each character takes 44 cycles (FETCH + WAIT + 42 DRAW).
  - done is asserted 44*len + 1 cycles after E, or 1 cycle after E when len==0.
- busy is 1 in FETCH, WAIT and DRAW; 0 in IDLE and FIN.
- plot is 1 only in DRAW, and only when x<X_MAX and y<Y_MAX.
- Arithmetic and clipping:
  - x is computed modulo 2**X_W; y is computed modulo 2**Y_W.
  - Clipped and wrapped pixels have plot=0 but still consume their cycle, so timing never depends on position.
- x, y and colour hold their last values outside DRAW.
- start while busy or in FIN is ignored; there is no queuing.
- Input changes after start have no effect until the next start.
- ram_address holds its last value outside FETCH.
- Font codes:
  - 0x0-0x9: digits 0-9.
  - 0xA-0xE: letters A-E.
  - 0xF: solid block, all 35 bits on.

Optional Feature:
- Macro: TEXT_PLOTTER_TRANSPARENT_EN.
- When defined: pixels that would use bg_colour (glyph-off bits and the gap column) are emitted with plot=0. Cycle timing is unchanged.
- When undefined: bg pixels are plotted in bg_colour, as specified above.

Decomposition:
- Package text_plotter_pkg holds:
  - GLYPH_W, GLYPH_H, CELL_W=6;
  - the state enum;
  - the 16x35-bit font bitmap constant.
- Sub-module font_rom: combinational; input code plus row index cy; output the 5-bit row of the glyph.
- The FSM, counters and coordinate adders stay in text_plotter.

Test Plan:
- Length 1, solid block:
  - Setup: RAM[0]=0xF; start with x0=10, y0=20, len=1, fg=3'b111, bg=3'b000.
  - Required: 42 plot pulses; 35 with colour 7; 7 with colour 0, all at x=15.
  - First pixel (10,20) 3 cycles after start. done exactly 45 cycles after start.
- Multi-character pitch:
  - Setup: RAM[0..2]=0xF; len=3, x0=0.
  - Required: cells start at x=0, 6, 12; 126 plots. busy high for 132 cycles; done at cycle 133.
- len=0:
  - Required: no plot; done one cycle after start; busy never high.
- Clipping:
  - Setup: x0=157, y0=118, len=1, code 0xF.
  - Required: only pixels with x in 157..159 and y in 118..119 have plot=1, i.e. 6 pulses. done still at cycle 45.
- Ignored start and async reset:
  - Stimulus: pulse start mid-DRAW; the run is unaffected. Then assert resetn=0 mid-DRAW.
  - Required: plot, busy, done, x, y go to 0 immediately; after release, a new start with len=2 completes in 89 cycles.
- TRANSPARENT_EN build:
  - Setup: code 0x1, fg=7.
  - Required: the plot count equals the font's on-bit count for '1'; no plot with colour==bg; done at cycle 45.

Source files
------------

// File: rtl/text_plotter_pkg.sv
// Shared constants for the text plotter: glyph geometry, FSM encodings, font.
// Latency: n/a (constants only).
// Backpressure: n/a.
package text_plotter_pkg;

    localparam int GLYPH_W    = 5;
    localparam int GLYPH_H    = 7;
    localparam int CELL_W     = 6;                 // glyph plus one gap column
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_DRAW  = 3'd3;
    localparam state_t S_FIN   = 3'd4;

    // One entry per code. Row 0 sits in the top five bits; within a row the
    // MSB is the leftmost column.
    localparam logic [GLYPH_BITS-1:0] FONT [0:15] = '{
        35'b01110_10001_10011_10101_11001_10001_01110,  // 0
        35'b00100_01100_00100_00100_00100_00100_01110,  // 1
        35'b01110_10001_00001_00010_00100_01000_11111,  // 2
        35'b11111_00010_00100_00010_00001_10001_01110,  // 3
        35'b00010_00110_01010_10010_11111_00010_00010,  // 4
        35'b11111_10000_11110_00001_00001_10001_01110,  // 5
        35'b00110_01000_10000_11110_10001_10001_01110,  // 6
        35'b11111_00001_00010_00100_01000_01000_01000,  // 7
        35'b01110_10001_10001_01110_10001_10001_01110,  // 8
        35'b01110_10001_10001_01111_00001_00010_01100,  // 9
        35'b01110_10001_10001_11111_10001_10001_10001,  // A
        35'b11110_10001_10001_11110_10001_10001_11110,  // B
        35'b01110_10001_10000_10000_10000_10001_01110,  // C
        35'b11100_10010_10001_10001_10001_10010_11100,  // D
        35'b11111_10000_10000_11110_10000_10000_11111,  // E
        35'b11111_11111_11111_11111_11111_11111_11111   // solid block
    };

endpackage

// File: rtl/text_plotter_font_rom.sv
// Glyph row lookup: code + row index -> 5 pixel bits (MSB = leftmost column).
// Latency: combinational.
// Backpressure: none. Ports: code, cy in; row out (zero for cy >= GLYPH_H).
module font_rom
    import text_plotter_pkg::*;
(
    input  logic [3:0]         code,
    input  logic [2:0]         cy,
    output logic [GLYPH_W-1:0] row
);

    logic [GLYPH_BITS-1:0] glyph;

    always_comb begin
        glyph = FONT[code];
        row   = '0;
        case (cy)
            3'd0:    row = glyph[34:30];
            3'd1:    row = glyph[29:25];
            3'd2:    row = glyph[24:20];
            3'd3:    row = glyph[19:15];
            3'd4:    row = glyph[14:10];
            3'd5:    row = glyph[9:5];
            3'd6:    row = glyph[4:0];
            default: row = '0;
        endcase
    end

endmodule

// File: rtl/text_plotter.sv
// Renders len character codes from the char RAM as 5x7 glyphs, one pixel/cycle.
// Latency: 44 cycles per char (fetch, RAM wait, 42 pixels); done 44*len+1 after start.
// Backpressure: none; start ignored while busy/FIN. Macro TEXT_PLOTTER_TRANSPARENT_EN
// suppresses plot on background pixels. Ports: start/x0/y0/len/fg/bg request,
// ram_address/ram_q RAM read, x/y/colour/plot pixel out, busy/done status.
module text_plotter
    import text_plotter_pkg::*;
#(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int X_MAX  = 160,
    parameter int Y_MAX  = 120,
    parameter int ADDR_W = 5,
    parameter int CHAR_W = 4,
    parameter int COL_W  = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [ADDR_W:0]   len,
    input  logic [COL_W-1:0]  fg_colour,
    input  logic [COL_W-1:0]  bg_colour,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [CHAR_W-1:0] ram_q,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [COL_W-1:0]  colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_MAX);

    state_t              state;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     idx;
    logic [X_W-1:0]      x_base;     // left column of the current cell
    logic [Y_W-1:0]      y0_r;
    logic [COL_W-1:0]    fg_r;
    logic [COL_W-1:0]    bg_r;
    logic [CHAR_W-1:0]   code_r;
    logic [2:0]          cx;
    logic [2:0]          cy;
    logic [X_W-1:0]      x_hold;
    logic [Y_W-1:0]      y_hold;
    logic [COL_W-1:0]    colour_hold;

    logic [GLYPH_W-1:0]  glyph_row;
    logic [GLYPH_W-1:0]  row_sh;
    logic [X_W-1:0]      x_pix;
    logic [Y_W-1:0]      y_pix;
    logic [COL_W-1:0]    pix_colour;
    logic                font_on;
    logic                in_view;
    logic                pix_en;
    logic                drawing;
    logic [ADDR_W:0]     idx_nxt;

    font_rom u_font (
        .code (code_r[3:0]),
        .cy   (cy),
        .row  (glyph_row)
    );

    // Shifting the row left by cx puts the current column in the MSB; the gap
    // column (cx == 5) shifts everything out, so it always reads as background.
    assign row_sh     = glyph_row << cx;
    assign font_on    = row_sh[GLYPH_W-1];
    assign x_pix      = x_base + X_W'(cx);
    assign y_pix      = y0_r + Y_W'(cy);
    assign pix_colour = font_on ? fg_r : bg_r;
    assign in_view    = ({1'b0, x_pix} < X_LIM) && ({1'b0, y_pix} < Y_LIM);
    assign drawing    = (state == S_DRAW);
    assign idx_nxt    = idx + (ADDR_W+1)'(1);

`ifdef TEXT_PLOTTER_TRANSPARENT_EN
    assign pix_en = in_view && font_on;
`else
    assign pix_en = in_view;
`endif

    assign plot   = drawing && pix_en;
    assign busy   = (state == S_FETCH) || (state == S_WAIT) || drawing;
    assign done   = (state == S_FIN);
    assign x      = drawing ? x_pix      : x_hold;
    assign y      = drawing ? y_pix      : y_hold;
    assign colour = drawing ? pix_colour : colour_hold;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            len_r       <= '0;
            idx         <= '0;
            x_base      <= '0;
            y0_r        <= '0;
            fg_r        <= '0;
            bg_r        <= '0;
            code_r      <= '0;
            cx          <= '0;
            cy          <= '0;
            x_hold      <= '0;
            y_hold      <= '0;
            colour_hold <= '0;
            ram_address <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_r  <= len;
                        x_base <= x0;
                        y0_r   <= y0;
                        fg_r   <= fg_colour;
                        bg_r   <= bg_colour;
                        idx    <= '0;
                        cx     <= '0;
                        cy     <= '0;
                        if (len == '0) begin
                            state <= S_FIN;
                        end else begin
                            state       <= S_FETCH;
                            ram_address <= '0;
                        end
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    code_r <= ram_q;
                    state  <= S_DRAW;
                end
                S_DRAW: begin
                    x_hold      <= x_pix;
                    y_hold      <= y_pix;
                    colour_hold <= pix_colour;
                    if (cx == 3'(CELL_W-1)) begin
                        cx <= '0;
                        if (cy == 3'(GLYPH_H-1)) begin
                            cy     <= '0;
                            idx    <= idx_nxt;
                            x_base <= x_base + X_W'(CELL_W);
                            if (idx_nxt == len_r) begin
                                state <= S_FIN;
                            end else begin
                                state       <= S_FETCH;
                                ram_address <= idx_nxt[ADDR_W-1:0];
                            end
                        end else begin
                            cy <= cy + 3'd1;
                        end
                    end else begin
                        cx <= cx + 3'd1;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
